vote_collector: RTL

// - Upstream input stage for the 3-input majority voter: turns three raw, bouncy voter buttons into clean one-per-session votes.
// - Per channel: 2-FF synchroniser, debouncer, rising-edge detect, sticky vote latch.
// - A session FSM opens a timed voting window, then freezes the votes.
// - vote_a/b/c feed the majority stage's A/B/C; vote_valid qualifies them.

---
 rtl/vote_collector.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vote_collector.sv
// vote_collector
// Input stage for the 3-input majority voter. It turns three raw, bouncy voter
// buttons into clean votes, one per session.
//
// Each button channel goes through these steps in order:
//   2-FF synchroniser -> debouncer -> rising-edge detect -> vote latch.
// A session FSM (IDLE -> COLLECT -> HOLD) opens a timed voting window and then
// freezes the votes.
//
// Optional feature macro: VOTE_RECAST_EN
//   defined   : in COLLECT, a press toggles its latch, so a second press
//               retracts the vote.
//   undefined : a press only sets its latch, so the vote is sticky.
//
// Parameters:
//   DEB_CYCLES : consecutive stable cycles needed before the debounced level
//                changes (>= 2).
//   WIN_CYCLES : voting-window length in clk cycles (>= 2).
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst        in   synchronous, active-high reset
//   start      in   one-cycle pulse that opens a voting session
//   clear      in   one-cycle pulse that ends or aborts a session (wins over all)
//   btn[2:0]   in   raw asynchronous buttons: [0]=A, [1]=B, [2]=C
//   vote_a/b/c out  latched votes, visible live during COLLECT
//   vote_valid out  high in HOLD: votes are frozen and final
//   collecting out  high in COLLECT: the voting window is open
module vote_collector #(
  parameter int DEB_CYCLES = 1000000,
  parameter int WIN_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [2:0] btn,
  output logic       vote_a,
  output logic       vote_b,
  output logic       vote_c,
  output logic       vote_valid,
  output logic       collecting
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int WW = $clog2(WIN_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [2:0]      s1, s2, deb, deb_d;
  logic [DW-1:0]   cnt [3];
  logic [2:0]      press;
  logic [2:0]      latch, latch_n;
  logic [WW-1:0]   win, win_n;

  // Synchroniser and debouncer. These run in every state, so a button that is
  // already held when start arrives produces no edge. It must be released and
  // pressed again to vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] != deb[i]) begin
          if (cnt[i] == DEB_LAST) begin
            deb[i] <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          // Any return to the current level restarts the stability count.
          cnt[i] <= '0;
        end
      end
    end
  end

  // One-cycle pulse on each debounced rise.
  assign press = deb & ~deb_d;

  always_comb begin
    state_n = state;
    latch_n = latch;
    win_n   = win;
    case (state)
      IDLE: begin
        latch_n = '0;
        win_n   = '0;
        if (start) state_n = COLLECT;
      end
      COLLECT: begin
`ifdef VOTE_RECAST_EN
        latch_n = latch ^ press;
`else
        latch_n = latch | press;
`endif
        win_n = win + WW'(1);
        // latch_n includes this cycle's presses, so a press that lands in the
        // exit cycle is still counted.
        if (win == WIN_LAST || latch_n == 3'b111) state_n = HOLD;
      end
      HOLD: begin
        // Votes stay frozen. Presses and start are ignored here.
      end
      default: begin
        state_n = IDLE;
        latch_n = '0;
        win_n   = '0;
      end
    endcase
    // clear wins over start and presses in every state.
    if (clear) begin
      state_n = IDLE;
      latch_n = '0;
      win_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      latch      <= '0;
      win        <= '0;
      vote_valid <= 1'b0;
      collecting <= 1'b0;
    end else begin
      state      <= state_n;
      latch      <= latch_n;
      win        <= win_n;
      // Status flags are loaded from the next state so they stay aligned
      // with the state register.
      vote_valid <= (state_n == HOLD);
      collecting <= (state_n == COLLECT);
    end
  end

  // The latch register drives the vote outputs directly.
  assign vote_a = latch[0];
  assign vote_b = latch[1];
  assign vote_c = latch[2];

endmodule
